ai_collide_sensor: RTL and testbench
====================================

# ai_collide_sensor

Per-frame collision sensor for the AI opponent car. It computes the 4-bit `AICollide` vector that the AI driving logic consumes: obstacle ahead, contact from behind, blocked left, blocked right. Inputs are the player and AI screen positions plus road-wall geometry. The block sits between the car position registers and the AI state machine, runs on `frame_clk`, and also keeps a saturating count of player/AI contact events for scoring.

## Interface
- `CAR_W`, 47, car width in pixels
- `CAR_H`, 67, car height in pixels
- `ROAD_X_MIN`, 325, left road wall X
- `ROAD_X_MAX`, 495, right road wall X
- `LOOKAHEAD`, 40, extra pixels ahead of the AI car that count as "obstacle ahead"
- `SIDE_MARGIN`, 4, lateral clearance in pixels for wall and side tests
- `HOLD_FRAMES`, 8, frames a flag is stretched after its condition clears
- `frame_clk`  in  1  frame clock; all state updates on its rising edge
- `Reset_n`  in  1  asynchronous, active-low reset
- `GameStart`  in  1  level; high while a race is running
- `inFrame`  in  1  AI car visible on screen
- `PlayerX`, `PlayerY`  in  10 each  player car top-left, screen pixels, unsigned
- `AIX`, `AIY`  in  10 each  AI car top-left, screen pixels, unsigned
- `AICollide`  out  4  [0] ahead, [1] behind, [2] left blocked, [3] right blocked
- `Contact`  out  1  one-frame pulse on each new player/AI overlap
- `CrashCount`  out  8  saturating count of `Contact` pulses

## Operation
- States:
  - IDLE: all flags, hold counters and pipeline registers held at 0.
  - ACTIVE: sensing.
- Transitions:
  - IDLE→ACTIVE on the first edge with `GameStart`=1.
  - ACTIVE→IDLE on the first edge with `GameStart`=0; flags clear on that edge.
  - `CrashCount` keeps its value across IDLE. Only reset clears it.
- Arithmetic:
  - All differences are computed in 11-bit signed form; no 10-bit wraparound is allowed.
  - dx = PlayerX−AIX, dy = PlayerY−AIY.
  - xov = |dx| < CAR_W.
  - yov = |dy| < CAR_H.
- Raw conditions, evaluated only in ACTIVE:
  - ahead = inFrame & xov & dy<0 & −dy < CAR_H+LOOKAHEAD
  - behind = inFrame & xov & dy≥0 & dy < CAR_H
  - left = AIX ≤ ROAD_X_MIN+SIDE_MARGIN | (inFrame & yov & dx<0 & −dx < CAR_W+SIDE_MARGIN)
  - right = AIX+CAR_W ≥ ROAD_X_MAX−SIDE_MARGIN | (inFrame & yov & dx>0 & dx < CAR_W+SIDE_MARGIN)
  - contact = inFrame & xov & yov
- Wall terms apply regardless of `inFrame`. Player terms are 0 when `inFrame`=0.
- Hold, per flag:
  - Raw=1 loads the counter with HOLD_FRAMES and drives the flag to 1.
  - Raw=0 with counter>0 decrements the counter; the flag stays 1.
  - Counter=0 drives the flag to 0.
  - Raw=1 while counting reloads the counter.
- `Contact` pulses on the rising edge of registered contact only.
- `CrashCount` increments by one per pulse and saturates at 255.

## Timing
- Two-stage pipeline: inputs sampled at edge N, raw conditions registered at N, `AICollide`/`Contact` valid after edge N+1.
- Reset values: `AICollide`=0, `Contact`=0, `CrashCount`=0, state IDLE, hold counters 0.
- Reset mid-race clears everything immediately (asynchronous). After `Reset_n` releases, the block waits for `GameStart` again.
- Simultaneous left and right, e.g. wall plus player on the other side: both flags are set; there is no priority.
- Contact held for many frames produces a single `Contact` pulse. A new pulse requires contact=0 for at least one frame.
- A `GameStart` drop while flags are held forces them to 0 on that edge; the hold is not completed.

## Configuration
- `COLLIDE_HOLD_EN` defined: hold counters are present; flags are stretched HOLD_FRAMES frames as above.
- `COLLIDE_HOLD_EN` undefined:
  - No hold counters are built.
  - Each `AICollide` bit equals its raw condition delayed by the same two-stage latency.
  - `HOLD_FRAMES` is ignored.

## Test plan
- Ahead, no contact: GameStart=1, inFrame=1, AI (400,200), player (410,110). Required: `AICollide`=4'b0001 two edges later, `Contact`=0, `CrashCount`=0.
- Contact: player moved to (410,150) and held 5 frames. Required: `AICollide`[0]=1, one `Contact` pulse, `CrashCount`=1. Player away 1 frame then back: `CrashCount`=2.
- Walls: AI (327,200), player off-road at (100,400) → 4'b0100. AI (445,200) → 4'b1000. Same AIX with inFrame=0: wall flags unchanged.
- Hold (macro defined): `left` asserted once, then cleared. Required: bit[2] stays 1 for exactly 8 frames after the clear and is 0 on the 9th. Without the macro it drops after the same 2-edge latency.
- Saturation and reset: 300 contact pulses → `CrashCount`=255. `Reset_n`=0 mid-hold → all outputs 0 immediately. After release with GameStart=0, outputs stay 0.

Source files
------------

// File: rtl/ai_collide_sensor.sv
// ---------------------------------------------------------------------------
// ai_collide_sensor
//
// Per-frame collision sensor for the AI opponent car. Produces the 4-bit
// AICollide vector consumed by the AI driving logic, a one-frame Contact
// pulse on each new player/AI overlap, and a saturating CrashCount.
//
// Build option:
//   COLLIDE_HOLD_EN  defined   -> each flag is stretched HOLD_FRAMES frames
//                                 after its raw condition clears.
//                    undefined -> flags are the raw conditions, delayed by
//                                 the same two-stage latency; no counters.
//
// Ports:
//   frame_clk   in   1   frame clock, all state updates on rising edge
//   Reset_n     in   1   asynchronous active-low reset
//   GameStart   in   1   level, high while a race is running
//   inFrame     in   1   AI car visible on screen
//   PlayerX/Y   in  10   player car top-left (screen pixels, unsigned)
//   AIX/AIY     in  10   AI car top-left (screen pixels, unsigned)
//   AICollide   out  4   [0] ahead, [1] behind, [2] left blocked, [3] right
//   Contact     out  1   one-frame pulse on each new player/AI overlap
//   CrashCount  out  8   saturating count of Contact pulses
//
// Pipeline: raw conditions are registered on edge N from the inputs sampled
// at edge N; AICollide/Contact/CrashCount update on edge N+1.
// ---------------------------------------------------------------------------

`ifdef COLLIDE_HOLD_EN
// One flag's hold stretcher: a raw hit reloads the counter, the flag stays
// high until the counter has run down to zero.
module ai_collide_hold #(
   parameter int HOLD_FRAMES = 8
) (
   input  logic frame_clk,
   input  logic Reset_n,
   input  logic i_clr,
   input  logic i_raw,
   output logic o_flag
);
   localparam int CW = $clog2(HOLD_FRAMES + 1);

   logic [CW-1:0] r_cnt;
   logic          r_flag;

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_cnt  <= '0;
         r_flag <= 1'b0;
      end else if (i_clr) begin
         // leaving the race abandons any hold in progress
         r_cnt  <= '0;
         r_flag <= 1'b0;
      end else if (i_raw) begin
         r_cnt  <= CW'(HOLD_FRAMES);
         r_flag <= 1'b1;
      end else if (r_cnt != '0) begin
         r_cnt  <= r_cnt - CW'(1);
         r_flag <= 1'b1;
      end else begin
         r_flag <= 1'b0;
      end
   end

   assign o_flag = r_flag;
endmodule
`endif

module ai_collide_sensor #(
   parameter int CAR_W       = 47,
   parameter int CAR_H       = 67,
   parameter int ROAD_X_MIN  = 325,
   parameter int ROAD_X_MAX  = 495,
   parameter int LOOKAHEAD   = 40,
   parameter int SIDE_MARGIN = 4,
   parameter int HOLD_FRAMES = 8
) (
   input  logic       frame_clk,
   input  logic       Reset_n,
   input  logic       GameStart,
   input  logic       inFrame,
   input  logic [9:0] PlayerX,
   input  logic [9:0] PlayerY,
   input  logic [9:0] AIX,
   input  logic [9:0] AIY,
   output logic [3:0] AICollide,
   output logic       Contact,
   output logic [7:0] CrashCount
);
   localparam int NUM_FLAGS = 4;

   // 11-bit constants so every compare sees the full unwrapped range
   localparam logic [10:0] L_CW     = 11'(CAR_W);
   localparam logic [10:0] L_CH     = 11'(CAR_H);
   localparam logic [10:0] L_AHEAD  = 11'(CAR_H + LOOKAHEAD);
   localparam logic [10:0] L_SIDE   = 11'(CAR_W + SIDE_MARGIN);
   localparam logic [10:0] L_WALL_L = 11'(ROAD_X_MIN + SIDE_MARGIN);
   localparam logic [10:0] L_WALL_R = 11'(ROAD_X_MAX - SIDE_MARGIN);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t r_state, w_state_nxt;
   logic   w_run;

   // ---------------- geometry ----------------
   logic signed [10:0] w_dx, w_dy;
   logic        [10:0] w_adx, w_ady;
   logic        [10:0] w_ai_right;
   logic               w_xov, w_yov;
   logic               w_ahead, w_behind, w_left, w_right, w_contact;
   logic [NUM_FLAGS-1:0] w_raw;

   assign w_dx  = $signed({1'b0, PlayerX}) - $signed({1'b0, AIX});
   assign w_dy  = $signed({1'b0, PlayerY}) - $signed({1'b0, AIY});
   assign w_adx = w_dx[10] ? $unsigned(-w_dx) : $unsigned(w_dx);
   assign w_ady = w_dy[10] ? $unsigned(-w_dy) : $unsigned(w_dy);

   assign w_xov = (w_adx < L_CW);
   assign w_yov = (w_ady < L_CH);

   assign w_ai_right = {1'b0, AIX} + L_CW;

   // player terms need the AI car on screen; wall terms do not
   assign w_ahead   = inFrame & w_xov &  w_dy[10] & (w_ady < L_AHEAD);
   assign w_behind  = inFrame & w_xov & ~w_dy[10] & (w_ady < L_CH);
   assign w_left    = ({1'b0, AIX} <= L_WALL_L)
                    | (inFrame & w_yov & w_dx[10] & (w_adx < L_SIDE));
   assign w_right   = (w_ai_right >= L_WALL_R)
                    | (inFrame & w_yov & ~w_dx[10] & (w_adx != 11'd0)
                       & (w_adx < L_SIDE));
   assign w_contact = inFrame & w_xov & w_yov;

   assign w_raw = {w_right, w_left, w_behind, w_ahead};

   // ---------------- race state ----------------
   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (GameStart)  w_state_nxt = ACTIVE;
         ACTIVE:  if (!GameStart) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // The edge that enters ACTIVE already samples the geometry, and the edge
   // that leaves it clears everything, so gate on the state being entered.
   assign w_run = (w_state_nxt == ACTIVE);

   // ---------------- stage 1: registered raw conditions ----------------
   logic [NUM_FLAGS-1:0] r_raw;
   logic                 r_raw_ct;

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_raw    <= '0;
         r_raw_ct <= 1'b0;
      end else if (!w_run) begin
         r_raw    <= '0;
         r_raw_ct <= 1'b0;
      end else begin
         r_raw    <= w_raw;
         r_raw_ct <= w_contact;
      end
   end

   // ---------------- stage 2: flags ----------------
`ifdef COLLIDE_HOLD_EN
   logic [NUM_FLAGS-1:0] w_flags;

   for (genvar g = 0; g < NUM_FLAGS; g++) begin : g_hold
      ai_collide_hold #(.HOLD_FRAMES(HOLD_FRAMES)) u_hold (
         .frame_clk (frame_clk),
         .Reset_n   (Reset_n),
         .i_clr     (~w_run),
         .i_raw     (r_raw[g]),
         .o_flag    (w_flags[g])
      );
   end

   assign AICollide = w_flags;
`else
   logic [NUM_FLAGS-1:0] r_flags;

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n)    r_flags <= '0;
      else if (!w_run) r_flags <= '0;
      else             r_flags <= r_raw;
   end

   assign AICollide = r_flags;
`endif

   // ---------------- stage 2: contact edge and crash counter ----------------
   logic       r_ct_prev;
   logic       r_contact;
   logic [7:0] r_crash;
   logic       w_pulse;

   // rising edge of registered contact; prev is cleared in IDLE so a race
   // that starts in contact still scores once
   assign w_pulse = w_run & r_raw_ct & ~r_ct_prev;

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_ct_prev <= 1'b0;
         r_contact <= 1'b0;
         r_crash   <= 8'd0;
      end else begin
         r_ct_prev <= w_run & r_raw_ct;
         r_contact <= w_pulse;
         // count survives IDLE; only reset clears it
         if (w_pulse && (r_crash != 8'hFF)) r_crash <= r_crash + 8'd1;
      end
   end

   assign Contact    = r_contact;
   assign CrashCount = r_crash;

endmodule

// File: tb/tb_ai_collide_sensor.sv
// Scoreboard bench for ai_collide_sensor. A history-based reference model
// (flags = OR of the recent registered raw conditions) produces one expected
// output record per frame; a monitor pops and compares after every edge.
module tb_ai_collide_sensor;
   localparam int CAR_W       = 47;
   localparam int CAR_H       = 67;
   localparam int ROAD_X_MIN  = 325;
   localparam int ROAD_X_MAX  = 495;
   localparam int LOOKAHEAD   = 40;
   localparam int SIDE_MARGIN = 4;
   localparam int HOLD_FRAMES = 8;
`ifdef COLLIDE_HOLD_EN
   localparam int WIN = HOLD_FRAMES + 1;
`else
   localparam int WIN = 1;
`endif

   logic       frame_clk = 1'b0;
   logic       Reset_n   = 1'b0;
   logic       GameStart = 1'b0;
   logic       inFrame   = 1'b0;
   logic [9:0] PlayerX = '0, PlayerY = '0, AIX = '0, AIY = '0;
   logic [3:0] AICollide;
   logic       Contact;
   logic [7:0] CrashCount;

   always #5 frame_clk = ~frame_clk;

   ai_collide_sensor #(
      .CAR_W(CAR_W), .CAR_H(CAR_H), .ROAD_X_MIN(ROAD_X_MIN),
      .ROAD_X_MAX(ROAD_X_MAX), .LOOKAHEAD(LOOKAHEAD),
      .SIDE_MARGIN(SIDE_MARGIN), .HOLD_FRAMES(HOLD_FRAMES)
   ) dut (
      .frame_clk (frame_clk),
      .Reset_n   (Reset_n),
      .GameStart (GameStart),
      .inFrame   (inFrame),
      .PlayerX   (PlayerX),
      .PlayerY   (PlayerY),
      .AIX       (AIX),
      .AIY       (AIY),
      .AICollide (AICollide),
      .Contact   (Contact),
      .CrashCount(CrashCount)
   );

   typedef struct packed {
      logic [3:0] col;
      logic       ct;
      logic [7:0] cc;
   } exp_t;

   exp_t       expq[$];
   logic [4:0] hist[$];    // {contact, right, left, behind, ahead} per race frame
   int         crash_m = 0;
   int         n_vec   = 0;
   int         n_bad   = 0;
   string      phase   = "init";

   // raw conditions straight from the geometric rules, in plain integers
   function automatic logic [4:0] raw_of(input logic inf, input int px, py, ax, ay);
      int dx, dy, adx, ady;
      logic xov, yov, ah, bh, lf, rt, ct;
      dx  = px - ax;
      dy  = py - ay;
      adx = (dx < 0) ? -dx : dx;
      ady = (dy < 0) ? -dy : dy;
      xov = (adx < CAR_W);
      yov = (ady < CAR_H);
      ah  = inf && xov && (dy < 0) && (-dy < CAR_H + LOOKAHEAD);
      bh  = inf && xov && (dy >= 0) && (dy < CAR_H);
      lf  = (ax <= ROAD_X_MIN + SIDE_MARGIN) ||
            (inf && yov && (dx < 0) && (-dx < CAR_W + SIDE_MARGIN));
      rt  = (ax + CAR_W >= ROAD_X_MAX - SIDE_MARGIN) ||
            (inf && yov && (dx > 0) && (dx < CAR_W + SIDE_MARGIN));
      ct  = inf && xov && yov;
      return {ct, rt, lf, bh, ah};
   endfunction

   // Outputs after this edge depend only on frames sampled on earlier edges
   // of the current race: a flag is up if any of the last WIN samples raised
   // it; Contact is up if the newest sample touches and the one before did not.
   function automatic exp_t model_step(input logic rst, gs, inf, input int px, py, ax, ay);
      exp_t e;
      int n;
      logic [3:0] col;
      logic pulse;
      if (rst || !gs) begin
         hist.delete();
         if (rst) crash_m = 0;
         e.col = 4'd0;
         e.ct  = 1'b0;
         e.cc  = 8'(crash_m);
         return e;
      end
      n   = hist.size();
      col = 4'd0;
      for (int k = 0; k < WIN && k < n; k++) col |= hist[n-1-k][3:0];
      pulse = 1'b0;
      if (n >= 1 && hist[n-1][4]) pulse = (n < 2) ? 1'b1 : !hist[n-2][4];
      if (pulse && crash_m < 255) crash_m++;
      e.col = col;
      e.ct  = pulse;
      e.cc  = 8'(crash_m);
      hist.push_back(raw_of(inf, px, py, ax, ay));
      if (hist.size() > WIN + 2) void'(hist.pop_front());
      return e;
   endfunction

   task automatic check_zero(input string name);
      n_vec++;
      if (AICollide !== 4'd0 || Contact !== 1'b0 || CrashCount !== 8'd0) begin
         n_bad++;
         $display("FAIL %s: got AICollide=%b Contact=%b CrashCount=%0d, want all 0",
                  name, AICollide, Contact, CrashCount);
      end
   endtask

   task automatic frame(input logic rst, gs, inf, input int px, py, ax, ay);
      @(negedge frame_clk);
      Reset_n   = !rst;
      GameStart = gs;
      inFrame   = inf;
      PlayerX   = 10'(px);
      PlayerY   = 10'(py);
      AIX       = 10'(ax);
      AIY       = 10'(ay);
      expq.push_back(model_step(rst, gs, inf, px, py, ax, ay));
      if (rst) begin
         #1;
         check_zero({phase, "_async"});
      end
   endtask

   task automatic frames(input int cnt, input logic gs, inf, input int px, py, ax, ay);
      for (int i = 0; i < cnt; i++) frame(1'b0, gs, inf, px, py, ax, ay);
   endtask

   // monitor: every edge is an output frame
   initial begin
      exp_t e;
      forever begin
         @(posedge frame_clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            n_vec++;
            if ({AICollide, Contact, CrashCount} !== e) begin
               n_bad++;
               $display("FAIL %s: got AICollide=%b Contact=%b CrashCount=%0d, want AICollide=%b Contact=%b CrashCount=%0d",
                        phase, AICollide, Contact, CrashCount, e.col, e.ct, e.cc);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1);
   end

   initial begin
      int ax, ay, px, py;
      logic gs, inf;

      phase = "reset";
      #1 check_zero("reset_t0");
      for (int i = 0; i < 3; i++) frame(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);

      phase = "idle";
      frames(3, 1'b0, 1'b1, 410, 150, 400, 200);

      phase = "ahead";
      frames(4, 1'b1, 1'b1, 410, 110, 400, 200);

      phase = "contact";
      frames(5, 1'b1, 1'b1, 410, 150, 400, 200);
      frames(1, 1'b1, 1'b1, 410, 110, 400, 200);
      frames(4, 1'b1, 1'b1, 410, 150, 400, 200);

      phase = "walls";
      frames(4, 1'b1, 1'b1, 100, 400, 327, 200);
      frames(4, 1'b1, 1'b1, 100, 400, 445, 200);
      frames(4, 1'b1, 1'b0, 100, 400, 445, 200);
      frames(4, 1'b1, 1'b0, 100, 400, 327, 200);
      frames(3, 1'b1, 1'b1, 400, 205, 445, 200);  // right wall plus player left
      frames(3, 1'b1, 1'b1, 1000, 5, 5, 1000);    // far corners, no wraparound

      phase = "hold";
      frames(1, 1'b1, 1'b1, 100, 400, 327, 200);
      frames(12, 1'b1, 1'b1, 100, 400, 400, 200);

      phase = "hold_drop";
      frames(1, 1'b1, 1'b1, 100, 400, 327, 200);
      frames(2, 1'b1, 1'b1, 100, 400, 400, 200);
      frames(2, 1'b0, 1'b1, 100, 400, 400, 200);
      frames(4, 1'b1, 1'b1, 100, 400, 400, 200);

      phase = "random";
      for (int i = 0; i < 600; i++) begin
         gs  = ($urandom_range(0, 15) != 0);
         inf = ($urandom_range(0, 3) != 0);
         ax  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023))
                                            : int'($urandom_range(300, 520));
         ay  = int'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) == 0) begin
            px = int'($urandom_range(0, 1023));
            py = int'($urandom_range(0, 1023));
         end else begin
            px = ax + int'($urandom_range(0, 200)) - 100;
            py = ay + int'($urandom_range(0, 260)) - 130;
         end
         if (px < 0) px = 0;
         if (px > 1023) px = 1023;
         if (py < 0) py = 0;
         if (py > 1023) py = 1023;
         frame(1'b0, gs, inf, px, py, ax, ay);
      end

      phase = "saturate";
      for (int i = 0; i < 300; i++) begin
         frames(1, 1'b1, 1'b1, 410, 150, 400, 200);
         frames(1, 1'b1, 1'b1, 100, 400, 400, 200);
      end
      frames(3, 1'b1, 1'b1, 410, 150, 400, 200);

      phase = "reset_mid_hold";
      frames(1, 1'b1, 1'b1, 100, 400, 327, 200);
      frames(3, 1'b1, 1'b1, 100, 400, 400, 200);
      frame(1'b1, 1'b0, 1'b1, 100, 400, 327, 200);
      frame(1'b1, 1'b0, 1'b1, 100, 400, 327, 200);
      phase = "post_reset_idle";
      frames(4, 1'b0, 1'b1, 410, 150, 327, 200);
      phase = "post_reset_race";
      frames(4, 1'b1, 1'b1, 410, 150, 400, 200);

      repeat (3) @(posedge frame_clk);
      #2;
      n_vec++;
      if (expq.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected frames left unchecked, want 0", expq.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
